// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: load returns normally win, buffered ALU
// results drain in order and are forced through after STARVE_MAX load grants.
module wb_port_arbiter #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 5,
  parameter int FIFO_DEPTH = 2,
  parameter int STARVE_MAX = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              alu_valid,
  output logic              alu_ready,
  input  logic [ADDR_W-1:0] alu_waddr,
  input  logic [DATA_W-1:0] alu_wdata,
  input  logic              mem_valid,
  output logic              mem_ready,
  input  logic [ADDR_W-1:0] mem_waddr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              wb_sel,
  output logic              busy,
  output logic              dbg_state
);

  // Handshakes: a transfer happens in a cycle where valid && ready are both
  // high at the rising edge; ready never depends on valid in the same cycle.

  typedef enum logic {
    PRI_MEM = 1'b0,
    PRI_ALU = 1'b1
  } state_e;

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(STARVE_MAX + 1);
  localparam int EW = ADDR_W + DATA_W;

  logic [EW-1:0]     fifo_mem_q [FIFO_DEPTH];
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW:0]       count_q, count_d;
  logic              fifo_empty, fifo_full;
  logic              push, pop;
  logic [EW-1:0]     head;

  state_e            state_q, state_d;
  logic [CW-1:0]     starve_q, starve_d;
  logic              grant_mem, grant_alu;

  logic              rf_we_q, rf_we_d;
  logic [ADDR_W-1:0] rf_waddr_q, rf_waddr_d;
  logic [DATA_W-1:0] rf_wdata_q, rf_wdata_d;
  logic              wb_sel_q, wb_sel_d;

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == (PW+1)'(FIFO_DEPTH));
  assign head       = fifo_mem_q[rd_ptr_q];

  // Arbitration uses the registered FIFO state, so a push into an empty FIFO
  // cannot be granted in its own cycle.
  always_comb begin
    state_d   = state_q;
    starve_d  = starve_q;
    grant_mem = 1'b0;
    grant_alu = 1'b0;
    mem_ready = 1'b1;
    case (state_q)
      PRI_MEM: begin
        if (mem_valid) begin
          grant_mem = 1'b1;
          if (!fifo_empty) begin
            starve_d = starve_q + 1'b1;
            if (starve_d == CW'(STARVE_MAX)) state_d = PRI_ALU;
          end
        end else if (!fifo_empty) begin
          grant_alu = 1'b1;
          starve_d  = '0;
        end
      end
      PRI_ALU: begin
        mem_ready = 1'b0;
        grant_alu = !fifo_empty;
        starve_d  = '0;
        state_d   = PRI_MEM;
      end
      default: state_d = PRI_MEM;
    endcase
  end

  assign alu_ready = !fifo_full;
  assign push      = alu_valid && !fifo_full;
  assign pop       = grant_alu;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Address 0 is a valid grant that consumes the entry but never writes.
  always_comb begin
    rf_we_d    = 1'b0;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    wb_sel_d   = wb_sel_q;
    if (grant_mem) begin
      rf_we_d    = (mem_waddr != '0);
      rf_waddr_d = mem_waddr;
      rf_wdata_d = mem_wdata;
      wb_sel_d   = 1'b1;
    end else if (grant_alu) begin
      rf_we_d    = (head[EW-1:DATA_W] != '0);
      rf_waddr_d = head[EW-1:DATA_W];
      rf_wdata_d = head[DATA_W-1:0];
      wb_sel_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= PRI_MEM;
      starve_q   <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
      wb_sel_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      starve_q   <= starve_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
      wb_sel_q   <= wb_sel_d;
    end
  end

  // Storage needs no reset: entries are only read when the count says valid.
  always_ff @(posedge clk) begin
    if (push) fifo_mem_q[wr_ptr_q] <= {alu_waddr, alu_wdata};
  end

  assign rf_we     = rf_we_q;
  assign rf_waddr  = rf_waddr_q;
  assign rf_wdata  = rf_wdata_q;
  assign wb_sel    = wb_sel_q;
  assign busy      = !fifo_empty || rf_we_q;
  assign dbg_state = (state_q == PRI_ALU);

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed and randomized bench for wb_port_arbiter against a queue-based
// model of the arbitration rules.
module tb_wb_port_arbiter;

  localparam int DATA_W     = 32;
  localparam int ADDR_W     = 5;
  localparam int FIFO_DEPTH = 2;
  localparam int STARVE_MAX = 3;
  localparam int EW         = ADDR_W + DATA_W;

  logic              clk;
  logic              rst_n;
  logic              alu_valid;
  logic              alu_ready;
  logic [ADDR_W-1:0] alu_waddr;
  logic [DATA_W-1:0] alu_wdata;
  logic              mem_valid;
  logic              mem_ready;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic              rf_we;
  logic [ADDR_W-1:0] rf_waddr;
  logic [DATA_W-1:0] rf_wdata;
  logic              wb_sel;
  logic              busy;
  logic              dbg_state;

  int checks = 0;
  int errors = 0;

  // Reference model: pending ALU results, loads granted since the oldest
  // pending ALU result arrived, and the expected register-file outputs.
  logic [EW-1:0]     exp_q[$];
  int                m_loads;
  bit                m_force;
  logic              m_we;
  logic              m_sel;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_data;

  wb_port_arbiter #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .FIFO_DEPTH(FIFO_DEPTH), .STARVE_MAX(STARVE_MAX)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_waddr(alu_waddr), .alu_wdata(alu_wdata),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .wb_sel(wb_sel), .busy(busy), .dbg_state(dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_loads = 0;
    m_force = 0;
    m_we    = 1'b0;
    m_sel   = 1'b0;
    m_addr  = '0;
    m_data  = '0;
  endtask

  // One clock cycle: drive, check ready outputs, advance the model, check
  // registered outputs after the edge, return at the next falling edge.
  task automatic step(input logic av, input logic [ADDR_W-1:0] aa, input logic [DATA_W-1:0] ad,
                      input logic mv, input logic [ADDR_W-1:0] ma, input logic [DATA_W-1:0] md);
    bit had, acc, win_alu, win_mem;
    logic [EW-1:0] head;
    alu_valid = av; alu_waddr = aa; alu_wdata = ad;
    mem_valid = mv; mem_waddr = ma; mem_wdata = md;
    #1;
    check_val("alu_ready", 64'(alu_ready), 64'(exp_q.size() < FIFO_DEPTH));
    check_val("mem_ready", 64'(mem_ready), 64'(!m_force));
    had = (exp_q.size() > 0);
    acc = av && (exp_q.size() < FIFO_DEPTH);
    win_alu = 0;
    win_mem = 0;
    if (m_force) begin
      win_alu = had;
      m_force = 0;
      m_loads = 0;
    end else if (mv) begin
      win_mem = 1;
      if (had) begin
        m_loads++;
        if (m_loads == STARVE_MAX) m_force = 1;
      end
    end else if (had) begin
      win_alu = 1;
      m_loads = 0;
    end
    m_we = 1'b0;
    if (win_mem) begin
      m_addr = ma; m_data = md; m_sel = 1'b1; m_we = (ma != 0);
    end else if (win_alu) begin
      head   = exp_q.pop_front();
      m_addr = head[EW-1:DATA_W];
      m_data = head[DATA_W-1:0];
      m_sel  = 1'b0;
      m_we   = (m_addr != 0);
    end
    if (acc) exp_q.push_back({aa, ad});
    @(posedge clk);
    #1;
    check_val("rf_we", 64'(rf_we), 64'(m_we));
    check_val("wb_sel", 64'(wb_sel), 64'(m_sel));
    check_val("busy", 64'(busy), 64'((exp_q.size() > 0) || m_we));
    if (m_we) begin
      check_val("rf_waddr", 64'(rf_waddr), 64'(m_addr));
      check_val("rf_wdata", 64'(rf_wdata), 64'(m_data));
    end
    @(negedge clk);
  endtask

  task automatic idle();
    step(1'b0, '0, '0, 1'b0, '0, '0);
  endtask

  initial begin
    rst_n = 1'b0;
    alu_valid = 1'b0; alu_waddr = '0; alu_wdata = '0;
    mem_valid = 1'b0; mem_waddr = '0; mem_wdata = '0;
    model_reset();
    #2;
    check_val("reset_rf_we", 64'(rf_we), 64'(0));
    check_val("reset_busy", 64'(busy), 64'(0));
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_val("rel_alu_ready", 64'(alu_ready), 64'(1));
    check_val("rel_mem_ready", 64'(mem_ready), 64'(1));
    check_val("rel_rf_wdata", 64'(rf_wdata), 64'(0));
    @(negedge clk);

    // ALU alone: write lands two cycles after the handshake
    step(1'b1, 5'd5, 32'h1234, 1'b0, '0, '0);
    check_val("alu_c1_rf_we", 64'(rf_we), 64'(0));
    idle();
    check_val("alu_c2_rf_we", 64'(rf_we), 64'(1));
    check_val("alu_c2_addr", 64'(rf_waddr), 64'(5));
    check_val("alu_c2_data", 64'(rf_wdata), 64'(32'h1234));
    check_val("alu_c2_sel", 64'(wb_sel), 64'(0));
    idle();

    // Contention: load first, ALU result next cycle
    step(1'b1, 5'd3, 32'h5, 1'b1, 5'd7, 32'hAAAA);
    check_val("cont_load_addr", 64'(rf_waddr), 64'(7));
    check_val("cont_load_sel", 64'(wb_sel), 64'(1));
    idle();
    check_val("cont_alu_addr", 64'(rf_waddr), 64'(3));
    check_val("cont_alu_sel", 64'(wb_sel), 64'(0));
    idle();

    // Starvation: three loads, forced ALU slot, then loads resume
    step(1'b1, 5'd1, 32'h1111, 1'b0, '0, '0);
    for (int i = 0; i < 3; i++) step(1'b0, '0, '0, 1'b1, 5'(20 + i), 32'(32'h100 + i));
    check_val("starve_mem_ready", 64'(mem_ready), 64'(0));
    step(1'b0, '0, '0, 1'b1, 5'd23, 32'h103);
    check_val("starve_alu_addr", 64'(rf_waddr), 64'(1));
    check_val("starve_alu_sel", 64'(wb_sel), 64'(0));
    step(1'b0, '0, '0, 1'b1, 5'd23, 32'h103);
    check_val("starve_resume_sel", 64'(wb_sel), 64'(1));
    idle();

    // Full FIFO under continuous loads; address-0 result gives no write
    step(1'b1, 5'd0, 32'hDEAD, 1'b1, 5'd9, 32'h9);
    step(1'b1, 5'd2, 32'hBEEF, 1'b1, 5'd10, 32'hA);
    check_val("full_alu_ready", 64'(alu_ready), 64'(0));
    step(1'b1, 5'd4, 32'h4444, 1'b1, 5'd11, 32'hB);
    step(1'b1, 5'd4, 32'h4444, 1'b1, 5'd12, 32'hC);
    step(1'b1, 5'd4, 32'h4444, 1'b1, 5'd13, 32'hD);
    check_val("zero_addr_rf_we", 64'(rf_we), 64'(0));
    step(1'b1, 5'd4, 32'h4444, 1'b1, 5'd14, 32'hE);
    repeat (4) idle();

    // Async reset mid-drain with the FIFO full
    step(1'b1, 5'd6, 32'h6666, 1'b1, 5'd12, 32'hC0);
    step(1'b1, 5'd8, 32'h8888, 1'b1, 5'd13, 32'hC1);
    rst_n = 1'b0;
    #1;
    check_val("arst_rf_we", 64'(rf_we), 64'(0));
    check_val("arst_rf_waddr", 64'(rf_waddr), 64'(0));
    check_val("arst_rf_wdata", 64'(rf_wdata), 64'(0));
    check_val("arst_wb_sel", 64'(wb_sel), 64'(0));
    check_val("arst_busy", 64'(busy), 64'(0));
    model_reset();
    alu_valid = 1'b0;
    mem_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) idle();

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 99) < 55), 5'($urandom_range(0, 31)), $urandom,
           ($urandom_range(0, 99) < 65), 5'($urandom_range(0, 31)), $urandom);
    end
    repeat (6) idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
